// File: rtl/aes_round_sched_if.sv
// Bundle between the AES round scheduler, host, key store and round engine.
// Latency: none, wires only.
// Backpressure: engine stalls the scheduler through rnd_ready; host start is only taken when idle.
interface aes_round_sched_if;
    logic         start;
    logic [127:0] pt;
    logic         busy;
    logic         done;
    logic [127:0] ct;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic [127:0] rnd_data;
    logic [127:0] rnd_key;
    logic         rnd_last;
    logic         rnd_rst;
    logic         rnd_ready;
    logic [127:0] rnd_out;
    logic         err;

    // scheduler side
    modport master (
        input  start, pt, key_data, rnd_ready, rnd_out,
        output busy, done, ct, key_addr, rnd_data, rnd_key, rnd_last, rnd_rst, err
    );

    // host / key store / engine side
    modport slave (
        output start, pt, key_data, rnd_ready, rnd_out,
        input  busy, done, ct, key_addr, rnd_data, rnd_key, rnd_last, rnd_rst, err
    );
endinterface

// File: rtl/aes_round_sched.sv
// AES-128 block sequencer: whitening with key 0, then ROUNDS launches of a shared round engine.
// Latency: 4-cycle lead-in, (2 + engine wait) per round minus one, done one cycle after final ready.
// Backpressure: start taken only in IDLE; WAIT holds until rnd_ready (watchdog via AES_SCHED_TIMEOUT_EN).
module aes_round_sched #(
    parameter int ROUNDS  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    aes_round_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH0, WHITEN, KEYW, LAUNCH, WAIT, DONE} state_t;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    // key_addr is 4 bits and the watchdog 5 bits; reject parameters that cannot fit
    if (ROUNDS < 1 || ROUNDS > 15) begin : g_chk_rounds
        $error("aes_round_sched: ROUNDS must be within 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 32) begin : g_chk_timeout
        $error("aes_round_sched: TIMEOUT must be within 1..32");
    end

    state_t       state, state_nxt;
    logic [127:0] st;
    logic [127:0] ct_q;
    logic [127:0] rnd_data_q;
    logic [127:0] rnd_key_q;
    logic [3:0]   key_addr_q;
    logic [3:0]   rcnt;
    logic         rnd_last_q;
    logic         final_rnd;
    logic         abort;
    logic         err_q;

    assign final_rnd = (rcnt == LAST_RND);

`ifdef AES_SCHED_TIMEOUT_EN
    logic [4:0] wd;

    // give up on an engine that never raises ready within TIMEOUT WAIT cycles
    assign abort = (state == WAIT) && !bus.rnd_ready && (wd == 5'(TIMEOUT - 1));

    // watchdog restarts at every launch; err is a one-cycle registered pulse in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
            if (state == LAUNCH) begin
                wd <= '0;
            end else if (state == WAIT && !bus.rnd_ready) begin
                wd <= wd + 5'd1;
            end
        end
    end
`else
    assign abort = 1'b0;
    assign err_q = 1'b0;
`endif

    // state register; reset wins over a coincident start
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and state-decoded outputs; engine is held in reset outside WAIT
    always_comb begin
        state_nxt   = state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.rnd_rst = 1'b1;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = FETCH0;
                end
            end
            FETCH0: begin
                bus.busy  = 1'b1;
                state_nxt = WHITEN;
            end
            WHITEN: begin
                bus.busy  = 1'b1;
                state_nxt = KEYW;
            end
            KEYW: begin
                bus.busy  = 1'b1;
                state_nxt = LAUNCH;
            end
            LAUNCH: begin
                // a leftover rnd_ready from the previous round is deliberately ignored here
                bus.busy  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                bus.busy    = 1'b1;
                bus.rnd_rst = 1'b0;
                if (bus.rnd_ready) begin
                    state_nxt = final_rnd ? DONE : KEYW;
                end else if (abort) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // datapath: block state, round counter, key address and engine operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= '0;
            ct_q       <= '0;
            key_addr_q <= '0;
            rcnt       <= '0;
            rnd_data_q <= '0;
            rnd_key_q  <= '0;
            rnd_last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        st         <= bus.pt;
                        key_addr_q <= 4'd0;
                        rcnt       <= 4'd1;
                    end
                end
                WHITEN: begin
                    st         <= st ^ bus.key_data;
                    key_addr_q <= 4'd1;
                end
                LAUNCH: begin
                    rnd_data_q <= st;
                    rnd_key_q  <= bus.key_data;
                    rnd_last_q <= final_rnd;
                end
                WAIT: begin
                    if (bus.rnd_ready) begin
                        st <= bus.rnd_out;
                        if (final_rnd) begin
                            ct_q <= bus.rnd_out;
                        end else begin
                            rcnt       <= rcnt + 4'd1;
                            key_addr_q <= key_addr_q + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ct       = ct_q;
    assign bus.key_addr = key_addr_q;
    assign bus.rnd_data = rnd_data_q;
    assign bus.rnd_key  = rnd_key_q;
    assign bus.rnd_last = rnd_last_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: AES round engine and key store models plus a ct scoreboard.
// Latency: engine answers in the 5th WAIT cycle; key store reads one cycle after the address.
// Backpressure: engine can hold ready low or raise a stale ready outside WAIT.
module tb_aes_round_sched;
    localparam int ROUNDS = 10;
    localparam int WR     = 5;
    localparam int LAT    = 4 + ROUNDS * (2 + WR) - 1 + 1;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_SCHED_TIMEOUT_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_round_sched_if bus();
    aes_round_sched #(.ROUNDS(ROUNDS), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_total = 0, n_bad = 0;
    int done_cnt = 0, err_cnt = 0, cyc = 0, acc_cyc = 0, round = 0, low_len = 0, last_len = 0;
    bit stale_en = 1'b0, hold = 1'b0, prev_busy = 1'b0, prev_rnd_rst = 1'b1;
    logic [127:0] last_ct = '0;
    logic [127:0] exp_q[$];
    logic [7:0]   sbox[256];
    logic [127:0] rk[16];
    logic [7:0]   eng_cnt;
    logic [127:0] eng_res;
    logic [127:0] pt2;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            end
            sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] t, o;
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) t[127 - 8 * i -: 8] = sbox[s[127 - 8 * i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8 * (r + 4 * c) -: 8] = t[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = o[127 - 32 * c -: 8];
                a1 = o[119 - 32 * c -: 8];
                a2 = o[111 - 32 * c -: 8];
                a3 = o[103 - 32 * c -: 8];
                o[127 - 32 * c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                o[119 - 32 * c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                o[111 - 32 * c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                o[103 - 32 * c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p);
        logic [127:0] s;
        s = p ^ rk[0];
        for (int r = 1; r <= ROUNDS; r++) s = aes_round(s, rk[r], r == ROUNDS);
        return s;
    endfunction

    // ---------------- environment models ----------------
    always @(posedge clk) begin
        bus.key_data <= rk[bus.key_addr];
        eng_cnt <= bus.rnd_rst ? 8'd0 : ((eng_cnt == 8'hff) ? eng_cnt : eng_cnt + 8'd1);
    end

    always_comb begin
        eng_res = aes_round(bus.rnd_data, bus.rnd_key, bus.rnd_last);
        if (bus.rnd_rst) begin
            bus.rnd_ready = stale_en;
            bus.rnd_out   = ~eng_res;
        end else begin
            bus.rnd_ready = !hold && (eng_cnt >= 8'(WR - 1));
            bus.rnd_out   = eng_res;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            round = 0;
            low_len = 0;
            last_ct = '0;
            exp_q.delete();
        end else begin
            if (bus.err) begin
                err_cnt++;
                round = 0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (bus.busy && !prev_busy) begin
                acc_cyc = cyc - 1;
                round = 0;
                check_eq("ct_hold", bus.ct, last_ct);
            end
            if (!bus.rnd_rst) begin
                if (prev_rnd_rst) begin
                    round++;
                    low_len = 0;
                    check_eq("key_addr", 128'(bus.key_addr), 128'(round));
                    check_eq("rnd_last", 128'(bus.rnd_last), 128'(round == ROUNDS));
                    check_eq("rnd_key", bus.rnd_key, rk[round % 16]);
                end
                low_len++;
            end else if (!prev_rnd_rst) begin
                last_len = low_len;
                if (round != 0 && !hold) check_eq("wait_len", 128'(low_len), 128'(WR));
            end
            if (bus.done) begin
                done_cnt++;
                check_eq("busy_with_done", 128'(bus.busy), 128'(0));
                check_eq("latency", 128'(cyc - acc_cyc + 1), 128'(LAT));
                check_eq("rounds", 128'(round), 128'(ROUNDS));
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", 128'(1), 128'(0));
                end else begin
                    last_ct = exp_q.pop_front();
                    check_eq("ct", bus.ct, last_ct);
                end
            end
        end
        prev_busy = bus.busy;
        prev_rnd_rst = bus.rnd_rst;
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_run(input logic [127:0] p, input logic [127:0] e);
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.pt = p;
        exp_q.push_back(e);
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.pt = ~p;
    endtask

    task automatic pulse_start(input logic [127:0] p);
        bus.start = 1'b1;
        bus.pt = p;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done_edge(input string tag);
        int n;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!bus.done && n < 300);
        if (!bus.done) check_eq(tag, 128'(0), 128'(1));
    endtask

    task automatic wait_round(input int r, input string tag);
        int n;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (round != r && n < 300);
        if (round != r) check_eq(tag, 128'(round), 128'(r));
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_busy"},     128'(bus.busy),     128'(0));
        check_eq({tag, "_done"},     128'(bus.done),     128'(0));
        check_eq({tag, "_ct"},       bus.ct,             128'(0));
        check_eq({tag, "_key_addr"}, 128'(bus.key_addr), 128'(0));
        check_eq({tag, "_rnd_data"}, bus.rnd_data,       128'(0));
        check_eq({tag, "_rnd_key"},  bus.rnd_key,        128'(0));
        check_eq({tag, "_rnd_last"}, 128'(bus.rnd_last), 128'(0));
        check_eq({tag, "_rnd_rst"},  128'(bus.rnd_rst),  128'(1));
        check_eq({tag, "_err"},      128'(bus.err),      128'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.start = 1'b0;
        bus.pt = '0;
        build_sbox();
        expand_key(KEY_C1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        @(posedge clk); #2;
        rst = 1'b0;

        // plain FIPS-197 C.1 block
        start_run(PT_C1, CT_C1);
        wait_done_edge("c1_timeout");

        // stale ready outside WAIT, stray starts in rounds 3, 7 and in DONE
        stale_en = 1'b1;
        start_run(PT_C1, CT_C1);
        wait_round(3, "r3_timeout");
        pulse_start({$urandom, $urandom, $urandom, $urandom});
        wait_round(7, "r7_timeout");
        pulse_start({$urandom, $urandom, $urandom, $urandom});
        wait_done_edge("stray_timeout");
        pulse_start({$urandom, $urandom, $urandom, $urandom});
        stale_en = 1'b0;
        repeat (5) @(posedge clk);
        #2 check_eq("done_start_ignored", 128'(bus.busy), 128'(0));

        // reset during WAIT of round 5, with a start on the reset edge
        start_run(PT_C1, CT_C1);
        wait_round(5, "r5_timeout");
        rst = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check_reset("mid");
        repeat (10) @(posedge clk);
        check_eq("no_done_after_rst", 128'(done_cnt), 128'(2));

        // fresh run, then a back-to-back second block
        start_run(PT_C1, CT_C1);
        wait_done_edge("fresh_timeout");
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        start_run(pt2, aes_ref(pt2));
        wait_done_edge("b2b_timeout");

`ifdef AES_SCHED_TIMEOUT_EN
        // engine never answers in round 2: watchdog abort
        repeat (3) @(posedge clk);
        start_run(PT_C1, CT_C1);
        wait_round(2, "to_r2_timeout");
        hold = 1'b1;
        begin
            int n;
            n = 0;
            while (!bus.err && n < 100) begin @(posedge clk); #2; n++; end
        end
        check_eq("to_err", 128'(bus.err), 128'(1));
        check_eq("to_busy", 128'(bus.busy), 128'(0));
        check_eq("to_done", 128'(bus.done), 128'(0));
        @(negedge clk); #1;
        check_eq("to_wait_len", 128'(last_len), 128'(16));
        @(posedge clk); #2;
        check_eq("to_err_pulse", 128'(bus.err), 128'(0));
        check_eq("to_ct_kept", bus.ct, last_ct);
        hold = 1'b0;
`endif

        repeat (5) @(posedge clk);
        check_eq("done_count", 128'(done_cnt), 128'(4));
        check_eq("err_count", 128'(err_cnt), 128'(EXP_ERR));
        check_eq("sb_left", 128'(exp_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
